// File: rtl/pt_block_queue.sv
// pt_block_queue: first-word fall-through FIFO that tags 64-bit plaintext words with first/last-of-message flags.
// Defining PTQ_DROP_COUNT_EN adds drop_cnt_o, an 8-bit saturating count of dropped input words.
module pt_block_queue #(
  parameter int DEPTH          = 4,
  parameter int BLOCKS_PER_MSG = 23
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  input  logic [63:0]                in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [63:0]                out_data_o,
  output logic                       out_first_o,
  output logic                       out_last_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
`ifdef PTQ_DROP_COUNT_EN
  ,
  output logic [7:0]                 drop_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int BLK_W = (BLOCKS_PER_MSG > 1) ? $clog2(BLOCKS_PER_MSG) : 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [BLK_W-1:0] LAST_BLK   = BLK_W'(BLOCKS_PER_MSG - 1);

  typedef struct packed {
    logic        first;
    logic        last;
    logic [63:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [BLK_W-1:0] blk_idx;
  logic             overflow;
  logic             async_rst;
  logic             rd_en;
  logic             wr_en;
  logic             drop;

  assign async_rst = reset_i | clear_i;
  assign rd_en     = out_valid_o & out_ready_i;
  // A read in the same cycle frees the slot, so a full queue can still accept.
  assign wr_en     = in_valid_i & ((level != FULL_LEVEL) | rd_en);
  assign drop      = in_valid_i & ~wr_en;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i or posedge async_rst) begin
    if (async_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      blk_idx  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      level <= level + LVL_W'(1);
      else if (rd_en && !wr_en) level <= level - LVL_W'(1);
      // Framing follows every upstream pulse, including dropped ones.
      if (in_valid_i) blk_idx <= (blk_idx == LAST_BLK) ? '0 : blk_idx + BLK_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; stale entries are never visible because outputs are masked by level.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{first: (blk_idx == '0), last: (blk_idx == LAST_BLK), data: in_data_i};
    end
  end

  // NOTE: every output gets a default before the conditional, so no latch is inferred.
  always_comb begin
    head        = mem[rd_ptr];
    out_valid_o = (level != '0);
    out_data_o  = '0;
    out_first_o = 1'b0;
    out_last_o  = 1'b0;
    if (out_valid_o) begin
      out_data_o  = head.data;
      out_first_o = head.first;
      out_last_o  = head.last;
    end
  end

  assign level_o    = level;
  assign overflow_o = overflow;

`ifdef PTQ_DROP_COUNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clock_i or posedge async_rst) begin
    if (async_rst)                      drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign drop_cnt_o = drop_cnt;
`endif

endmodule

// File: tb/tb_pt_block_queue.sv
// Self-checking bench for pt_block_queue: directed steps plus randomized traffic against a queue-based model.
// Covers drop_cnt_o when PTQ_DROP_COUNT_EN is defined.
module tb_pt_block_queue;

  localparam int DEPTH = 4;
  localparam int BPM   = 23;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clock_i;
  logic             reset_i;
  logic             clear_i;
  logic             in_valid_i;
  logic [63:0]      in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [63:0]      out_data_o;
  logic             out_first_o;
  logic             out_last_o;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;
`ifdef PTQ_DROP_COUNT_EN
  logic [7:0]       drop_cnt_o;
`endif

  pt_block_queue #(.DEPTH(DEPTH), .BLOCKS_PER_MSG(BPM)) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clear_i    (clear_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_first_o(out_first_o),
    .out_last_o (out_last_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
`ifdef PTQ_DROP_COUNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  typedef struct packed {
    logic        first;
    logic        last;
    logic [63:0] data;
  } ent_t;

  // Reference model: message position counter plus a plain queue of tagged words.
  ent_t q[$];
  int   m_blk;
  bit   m_ovf;
  int   m_drop;
  int   checks;
  int   failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [63:0] ed;
    logic        ef;
    logic        el;
    ev = (q.size() != 0);
    ed = ev ? q[0].data  : 64'h0;
    ef = ev ? q[0].first : 1'b0;
    el = ev ? q[0].last  : 1'b0;
    check({tag, "/valid"}, 64'(out_valid_o), 64'(ev));
    check({tag, "/data"},  out_data_o,       ed);
    check({tag, "/first"}, 64'(out_first_o), 64'(ef));
    check({tag, "/last"},  64'(out_last_o),  64'(el));
    check({tag, "/level"}, 64'(level_o),     64'(q.size()));
    check({tag, "/ovf"},   64'(overflow_o),  64'(m_ovf));
`ifdef PTQ_DROP_COUNT_EN
    check({tag, "/dropcnt"}, 64'(drop_cnt_o), 64'(m_drop));
`endif
  endtask

  task automatic model_edge(input logic v, input logic [63:0] d, input logic r);
    bit   rd;
    bit   wr;
    ent_t e;
    rd = (q.size() != 0) && r;
    wr = v && ((q.size() < DEPTH) || rd);
    if (rd) void'(q.pop_front());
    if (wr) begin
      e.first = (m_blk == 0);
      e.last  = (m_blk == BPM - 1);
      e.data  = d;
      q.push_back(e);
    end
    if (v && !wr) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    if (v) m_blk = (m_blk + 1) % BPM;
  endtask

  // One clock: drive inputs, check pre-edge outputs against the model, advance both.
  task automatic cycle(input logic v, input logic [63:0] d, input logic r);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    check_model("cyc");
    @(posedge clock_i);
    model_edge(v, d, r);
    #1;
    in_valid_i = 1'b0;
  endtask

  // Asynchronous reset or clear, checked before any clock edge arrives.
  task automatic do_reset(input bit use_clear);
    if (use_clear) clear_i = 1'b1;
    else           reset_i = 1'b1;
    q.delete();
    m_blk  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
    #1;
    check_model(use_clear ? "clear" : "reset");
    #1;
    clear_i = 1'b0;
    reset_i = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_i     = 1'b0;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    q.delete();
    m_blk  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;

    @(posedge clock_i);
    #1;
    do_reset(1'b0);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);

    // Single word with 1-cycle latency, then drained.
    cycle(1'b1, 64'h0011223344556677, 1'b1);
    check("single_valid", 64'(out_valid_o), 64'd1);
    check("single_data", out_data_o, 64'h0011223344556677);
    check("single_first", 64'(out_first_o), 64'd1);
    check("single_last", 64'(out_last_o), 64'd0);
    cycle(1'b0, 64'h0, 1'b1);
    check("single_drain_valid", 64'(out_valid_o), 64'd0);
    check("single_drain_level", 64'(level_o), 64'd0);

    // Two messages, sparse pulses: first/last framing.
    do_reset(1'b0);
    for (int k = 0; k < 46; k++) begin
      cycle(1'b1, 64'(k), 1'b1);
      check("frame_data", out_data_o, 64'(k));
      check("frame_first", 64'(out_first_o), 64'((k % 23) == 0));
      check("frame_last", 64'(out_last_o), 64'((k % 23) == 22));
      for (int j = 0; j < 7; j++) cycle(1'b0, 64'h0, 1'b1);
    end
    check("frame_ovf", 64'(overflow_o), 64'd0);

    // Overflow: fifth word dropped, framing still advances.
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) cycle(1'b1, 64'(k), 1'b0);
    check("ovf_level", 64'(level_o), 64'd4);
    check("ovf_flag", 64'(overflow_o), 64'd1);
`ifdef PTQ_DROP_COUNT_EN
    check("ovf_dropcnt", 64'(drop_cnt_o), 64'd1);
`endif
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", out_data_o, 64'(k));
      cycle(1'b0, 64'h0, 1'b1);
    end
    check("ovf_empty", 64'(out_valid_o), 64'd0);
    cycle(1'b1, 64'd6, 1'b1);
    check("sixth_first", 64'(out_first_o), 64'd0);
    check("sixth_last", 64'(out_last_o), 64'd0);
    for (int k = 0; k < 16; k++) cycle(1'b1, 64'(7 + k), 1'b1);
    cycle(1'b1, 64'd100, 1'b1);
    check("blk22_data", out_data_o, 64'd100);
    check("blk22_last", 64'(out_last_o), 64'd1);
    check("ovf_sticky", 64'(overflow_o), 64'd1);

    // Full queue with simultaneous read and write: no drop.
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 64'(10 + k), 1'b0);
    check("full_level", 64'(level_o), 64'd4);
    cycle(1'b1, 64'd14, 1'b1);
    check("full_rw_level", 64'(level_o), 64'd4);
    check("full_rw_ovf", 64'(overflow_o), 64'd0);
    check("full_rw_head", out_data_o, 64'd11);

    // Clear mid-message with three entries queued.
    do_reset(1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b1, 64'(k), 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    for (int k = 7; k < 10; k++) cycle(1'b1, 64'(k), 1'b0);
    check("pre_clear_level", 64'(level_o), 64'd3);
    do_reset(1'b1);
    check("clear_level", 64'(level_o), 64'd0);
    check("clear_valid", 64'(out_valid_o), 64'd0);
    cycle(1'b1, 64'hABCD, 1'b1);
    check("post_clear_first", 64'(out_first_o), 64'd1);
    check("post_clear_data", out_data_o, 64'hABCD);

    // Head stability under backpressure.
    do_reset(1'b0);
    cycle(1'b1, 64'hA, 1'b0);
    cycle(1'b1, 64'hB, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 64'h0, 1'b0);
      check("hold_valid", 64'(out_valid_o), 64'd1);
      check("hold_data", out_data_o, 64'hA);
      check("hold_first", 64'(out_first_o), 64'd1);
      check("hold_last", 64'(out_last_o), 64'd0);
    end

    // Long overflow run: drop counter saturation.
    do_reset(1'b0);
    for (int k = 0; k < 264; k++) cycle(1'b1, 64'(k), 1'b0);
    check("sat_level", 64'(level_o), 64'd4);
    check("sat_ovf", 64'(overflow_o), 64'd1);
`ifdef PTQ_DROP_COUNT_EN
    check("sat_dropcnt", 64'(drop_cnt_o), 64'hFF);
`endif

    // Randomized traffic with varying consumer throughput and occasional clears.
    do_reset(1'b0);
    for (int blk = 0; blk < 10; blk++) begin
      int rp;
      rp = $urandom_range(1, 9);
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset(1'b1);
        end else begin
          cycle(logic'($urandom_range(0, 9) < 5), {$urandom, $urandom},
                logic'($urandom_range(0, 9) < rp));
        end
      end
    end
    check_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pt_block_queue.md
Name: pt_block_queue

Overview:
- Downstream neighbour of the byte-packing register in the encryptor pipeline.
- Captures each 64-bit plaintext word on its 1-cycle valid pulse and buffers it in a small FIFO.
- Tags each word with first/last-of-message flags (BLOCKS_PER_MSG words per message).
- Presents words to the cipher core over a valid/ready handshake.
- The input side has no backpressure: the queue absorbs bursts and flags any loss.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- BLOCKS_PER_MSG, 23, words per message (22 full words + 1 padded word for 181 bytes).

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  asynchronous, active-high clear; same effect as reset_i.
- in_valid_i  in  1  1-cycle pulse; in_data_i is valid this cycle.
- in_data_i  in  64  plaintext word.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  consumer accepts head this cycle.
- out_data_o  out  64  head word.
- out_first_o  out  1  head word is block 0 of a message.
- out_last_o  out  1  head word is block BLOCKS_PER_MSG-1 of a message.
- level_o  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky; set when an input word was dropped.

Behaviour:
- Reset/clear (reset_i or clear_i high), asynchronous:
  - Pointers, level and block index go to 0.
  - out_valid_o=0, out_data_o=0, out_first_o=0, out_last_o=0, level_o=0, overflow_o=0.
- Storage:
  - Each entry holds {first, last, data[63:0]}.
  - Registered array with read/write pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
- Block index:
  - Counter blk_idx runs 0..BLOCKS_PER_MSG-1 and advances on every in_valid_i pulse, accepted or dropped, so framing stays aligned with upstream.
  - Wraps to 0 after BLOCKS_PER_MSG-1.
  - Stored first flag = (blk_idx==0); stored last flag = (blk_idx==BLOCKS_PER_MSG-1).
- Output (first-word fall-through):
  - out_valid_o = (level != 0).
  - out_data_o, out_first_o and out_last_o reflect the head entry.
  - When empty, these three are driven to 0.
- Transfer:
  - A read occurs when out_valid_o && out_ready_i.
  - A write occurs when in_valid_i && (level<DEPTH || read).
- Latency: a word written at edge N is visible with out_valid_o=1 after edge N, i.e. 1 cycle.
- Simultaneous read and write:
  - When not empty: level unchanged; both pointers advance.
  - When full: the read frees the slot, so the write is accepted and no drop occurs.
  - When empty: no read (out_valid_o=0); the write is accepted and level becomes 1.
- Full with in_valid_i and no read:
  - The word is dropped; the FIFO is unchanged.
  - overflow_o is set and stays 1 until reset/clear.
  - blk_idx still advances.
- out_ready_i while empty has no effect.
- The consumer must not see out_data_o change while out_valid_o=1 && !out_ready_i; head stability is guaranteed.
- Reset/clear mid-message: all contents are discarded and the next input word is tagged first.

Optional Feature:
- Macro: PTQ_DROP_COUNT_EN.
- When defined:
  - Adds output drop_cnt_o [7:0], an 8-bit saturating count of dropped words.
  - Reset/clear value 0; saturates at 8'hFF.
  - Increments in the same cycle overflow_o would be set.
- When undefined:
  - The port and counter are absent.
  - overflow_o behaviour is unchanged.

Test Plan:
- Reset, then one pulse in_data_i=64'h0011223344556677 with out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=64'h0011223344556677, out_first_o=1, out_last_o=0; following cycle out_valid_o=0, level_o=0.
- 46 pulses spaced 8 cycles apart, data = block number, out_ready_i=1 -> out_first_o=1 on words 0 and 23; out_last_o=1 on words 22 and 45; no overflow.
- out_ready_i=0, 5 consecutive pulses with data 1..5 -> level_o=4, overflow_o=1, drop_cnt_o=1 if PTQ_DROP_COUNT_EN; then ready=1 -> outputs 1,2,3,4 in order; the 6th input word is tagged as blk_idx 5.
- Full FIFO with out_ready_i=1 and in_valid_i in the same cycle -> level_o stays 4, overflow_o stays 0, head advances.
- Assert clear_i while level_o=3 mid-message (blk_idx=10) -> level_o=0 and out_valid_o=0 immediately; next input tagged out_first_o=1.
- Hold out_ready_i=0 for 10 cycles with 2 entries -> out_data_o and flags stable throughout.
